// File: rtl/serial_sub_pkg.sv
// Shared types and elaboration helpers for the serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Number of RUN cycles needed to cover the full operand width.
  function automatic int unsigned steps_of(input int unsigned width, input int unsigned bpc);
    return width / bpc;
  endfunction

  // Step counter is one bit wider than needed so it can hold STEPS itself.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return clog2(steps) + 1;
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = x - y - bi, built from two half-subtract stages.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic d1;
  logic b1;
  logic b2;

  // First half-subtract x - y, second subtracts the incoming borrow.
  always_comb begin
    d1 = x ^ y;
    b1 = ~x & y;
    d  = d1 ^ bi;
    b2 = ~d1 & bi;
    bo = b1 | b2;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-bit subtractor diff = a - b - bin, processing BPC bits per RUN cycle.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned STEPS = steps_of(WIDTH, BPC);
  localparam int unsigned CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if (WIDTH < 2 || BPC < 1 || BPC > WIDTH || (WIDTH % ((BPC < 1) ? 1 : BPC)) != 0) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be >= 2 and BPC must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [BPC:0]     chain;
  logic [BPC-1:0]   step_diff;
  logic [WIDTH-1:0] res_next;

  assign chain[0] = brw_q;

  // Ripple borrow through BPC cells on the low bits of the operand shifters.
  for (genvar i = 0; i < BPC; i++) begin : g_cell
    full_sub_cell u_cell (
      .x  (a_sh_q[i]),
      .y  (b_sh_q[i]),
      .bi (chain[i]),
      .d  (step_diff[i]),
      .bo (chain[i+1])
    );
  end

  // Next-state, datapath shifting and result latching.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    brw_d    = brw_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    // New bits enter from the MSB side; after STEPS shifts they sit in place.
    res_next = WIDTH'({step_diff, res_q} >> BPC);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> BPC;
        b_sh_d = b_sh_q >> BPC;
        res_d  = res_next;
        brw_d  = chain[BPC];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          diff_d  = res_next;
          bout_d  = chain[BPC];
          ovf_d   = (a_msb_q ^ b_msb_q) & (res_next[WIDTH-1] ^ a_msb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    diff = diff_q;
    bout = bout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 with BPC=1 and BPC=4).
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  typedef struct {
    bit         sel;   // 0: BPC=1 instance, 1: BPC=4 instance
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  logic       p1_start, p1_bin, p1_busy, p1_done, p1_bout, p1_ovf;
  logic [7:0] p1_a, p1_b, p1_diff;
  logic       p4_start, p4_bin, p4_busy, p4_done, p4_bout, p4_ovf;
  logic [7:0] p4_a, p4_b, p4_diff;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .BPC(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(p1_start), .a(p1_a), .b(p1_b), .bin(p1_bin),
    .busy(p1_busy), .done(p1_done), .diff(p1_diff), .bout(p1_bout), .ovf(p1_ovf)
  );

  serial_subtractor #(.WIDTH(8), .BPC(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(p4_start), .a(p4_a), .b(p4_b), .bin(p4_bin),
    .busy(p4_busy), .done(p4_done), .diff(p4_diff), .bout(p4_bout), .ovf(p4_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    logic [8:0] r;
    r    = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    e.d  = r[7:0];
    e.bo = r[8];
    e.ov = (a[7] ^ b[7]) & (r[7] ^ a[7]);
    return e;
  endfunction

  function automatic logic busy_s(input bit sel);
    return sel ? p4_busy : p1_busy;
  endfunction

  function automatic logic done_s(input bit sel);
    return sel ? p4_done : p1_done;
  endfunction

  // Scoreboard: each done pulse pops the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && p1_done) begin
      if (q1.size() == 0) chk("p1_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("p1_diff", {24'd0, p1_diff}, {24'd0, e.d});
        chk("p1_bout", {31'd0, p1_bout}, {31'd0, e.bo});
        chk("p1_ovf",  {31'd0, p1_ovf},  {31'd0, e.ov});
      end
    end
    if (!rst && p4_done) begin
      if (q4.size() == 0) chk("p4_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("p4_diff", {24'd0, p4_diff}, {24'd0, e.d});
        chk("p4_bout", {31'd0, p4_bout}, {31'd0, e.bo});
        chk("p4_ovf",  {31'd0, p4_ovf},  {31'd0, e.ov});
      end
    end
  end

  // One operation: start pulsed for one cycle, latency and busy length checked.
  task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input exp_t e);
    int unsigned steps;
    int unsigned edges;
    int unsigned nb;
    steps = sel ? 2 : 8;
    @(negedge clk);
    if (sel) begin p4_start = 1'b1; p4_a = a; p4_b = b; p4_bin = bin; q4.push_back(e); end
    else     begin p1_start = 1'b1; p1_a = a; p1_b = b; p1_bin = bin; q1.push_back(e); end
    @(posedge clk); #1;
    // Operands are don't-care once captured.
    if (sel) begin p4_start = 1'b0; p4_a = 8'($urandom); p4_b = 8'($urandom); p4_bin = 1'($urandom); end
    else     begin p1_start = 1'b0; p1_a = 8'($urandom); p1_b = 8'($urandom); p1_bin = 1'($urandom); end
    edges = 0;
    nb = 0;
    while (edges < 40) begin
      if (done_s(sel)) break;
      if (busy_s(sel)) nb++;
      @(posedge clk); #1;
      edges++;
    end
    chk(sel ? "p4_latency" : "p1_latency", edges, steps);
    chk(sel ? "p4_busy_len" : "p1_busy_len", nb, steps);
  endtask

  vec_t tbl[$];

  initial begin
    exp_t e;
    logic [7:0] ra, rb;
    logic       rbin;
    int unsigned k;

    tbl.push_back('{0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0});
    tbl.push_back('{0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0});
    tbl.push_back('{0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1});
    tbl.push_back('{0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0});
    tbl.push_back('{0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1});
    tbl.push_back('{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0});
    tbl.push_back('{1, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1});
    tbl.push_back('{1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0});
    tbl.push_back('{1, 8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 1'b1});

    p1_start = 0; p1_a = 0; p1_b = 0; p1_bin = 0;
    p4_start = 0; p4_a = 0; p4_b = 0; p4_bin = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_p1_outputs", {19'd0, p1_busy, p1_done, p1_diff, p1_bout, p1_ovf}, 32'd0);
    chk("rst_p4_outputs", {19'd0, p4_busy, p4_done, p4_diff, p4_bout, p4_ovf}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      e.d = tbl[i].d; e.bo = tbl[i].bo; e.ov = tbl[i].ov;
      run_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].bin, e);
    end

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      run_op(i[0], ra, rb, rbin, model(ra, rb, rbin));
    end

    // Back-to-back with start held high; a mid-RUN operand change only reaches op 2.
    @(negedge clk);
    p1_start = 1'b1; p1_a = 8'h10; p1_b = 8'h01; p1_bin = 1'b0;
    e.d = 8'h0F; e.bo = 1'b0; e.ov = 1'b0; q1.push_back(e);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    p1_a = 8'h20;
    e.d = 8'h1F; q1.push_back(e);
    k = 0;
    while (!p1_done && k < 20) begin @(posedge clk); #1; k++; end
    chk("b2b_first_done", {31'd0, p1_done}, 32'd1);
    chk("b2b_done_not_busy", {31'd0, p1_busy}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_no_idle_bubble", {30'd0, p1_busy, p1_done}, 32'd2);
    p1_start = 1'b0;
    k = 0;
    while (!p1_done && k < 20) begin @(posedge clk); #1; k++; end
    chk("b2b_second_done", {31'd0, p1_done}, 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN discards the operation.
    @(negedge clk);
    p1_start = 1'b1; p1_a = 8'h55; p1_b = 8'h11; p1_bin = 1'b0;
    @(posedge clk); #1;
    p1_start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, p1_busy}, 32'd0);
    chk("mid_rst_done", {31'd0, p1_done}, 32'd0);
    chk("mid_rst_diff", {24'd0, p1_diff}, 32'd0);
    chk("mid_rst_bout_ovf", {30'd0, p1_bout, p1_ovf}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", {30'd0, p1_busy, p1_done}, 32'd0);
    e.d = 8'h05; e.bo = 1'b0; e.ov = 1'b0;
    run_op(0, 8'h09, 8'h04, 1'b0, e);

    // Idle stability: results hold, no handshake activity.
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", {19'd0, p1_busy, p1_done, p1_diff, p1_bout, p1_ovf},
          {19'd0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0});
    end

    repeat (2) @(posedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1);
  end

endmodule
